aud_host_cmd: RTL

Byte-stream command front end for the AUD remote-memory master. It parses framed read/write requests from a host byte channel (UART/USB bridge side), issues single-shot transactions to the AUD RMM engine, waits for completion, and returns a status byte plus any read data on a transmit byte channel. It sits directly upstream of the RMM engine, in the same `aud_ck` domain.

---
 rtl/aud_host_cmd_if.sv | 31 +++
 rtl/aud_host_cmd.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/aud_host_cmd_if.sv
// Host byte channels and RMM request/response bundle for the AUD host command front end.
// master = command block side, slave = host bridge / RMM engine side.
interface aud_host_cmd_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rmm_addr;
    logic [31:0] rmm_wdata;
    logic [31:0] rmm_rdata;
    logic [1:0]  rmm_size;
    logic        rmm_we;
    logic        rmm_re;
    logic        rmm_done;
    logic        rmm_err;
    logic        rmm_abort;

    modport master (
        input  rx_data, rx_valid, tx_ready, rmm_rdata, rmm_done, rmm_err,
        output rx_ready, tx_data, tx_valid, rmm_addr, rmm_wdata, rmm_size,
               rmm_we, rmm_re, rmm_abort
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, rmm_rdata, rmm_done, rmm_err,
        input  rx_ready, tx_data, tx_valid, rmm_addr, rmm_wdata, rmm_size,
               rmm_we, rmm_re, rmm_abort
    );
endinterface

// File: rtl/aud_host_cmd.sv
// Parses framed host read/write bytes into single RMM transactions and returns status + read data.
// Request pulses the cycle after the last frame byte; rx held off outside frame states, tx bytes held until tx_ready.
module aud_host_cmd #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             aud_ck,
    input  logic             rst,
    aud_host_cmd_if.master   bus,
    output logic             busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_ISSUE,
        S_WAIT,
        S_RESP_STATUS,
        S_RESP_DATA
    } state_t;

    state_t          state, state_nxt;
    logic            is_wr;
    logic [1:0]      size;
    logic [1:0]      cnt;
    logic [TW-1:0]   tcnt;
    logic [31:0]     addr, wdata, rbuf;
    logic [7:0]      status;
    logic            rx_rdy, abort_q;
    logic            rx_fire, tx_fire, tx_vld, expire, op_ok;
    logic [1:0]      n_m1;
    logic [7:0]      tx_byte;

    assign op_ok   = (bus.rx_data[6:2] == 5'd0) && (bus.rx_data[1:0] != 2'd3);
    // Index of the last byte of an N = 1<<size payload: 0, 1 or 3.
    assign n_m1    = {size[1], size[1] | size[0]};
    assign rx_fire = bus.rx_valid && rx_rdy;
    assign tx_vld  = (state == S_RESP_STATUS) || (state == S_RESP_DATA);
    assign tx_fire = tx_vld && bus.tx_ready;

    always_comb begin
        state_nxt = state;
        expire    = 1'b0;
        case (state)
            S_IDLE:        if (rx_fire) state_nxt = op_ok ? S_ADDR : S_RESP_STATUS;
            S_ADDR:        if (rx_fire && cnt == 2'd3) state_nxt = is_wr ? S_WDATA : S_ISSUE;
            S_WDATA:       if (rx_fire && cnt == n_m1) state_nxt = S_ISSUE;
            S_ISSUE:       state_nxt = S_WAIT;
            S_WAIT: begin
                // Completion in the expiry cycle takes priority over the abort.
                if (bus.rmm_done) begin
                    state_nxt = S_RESP_STATUS;
                end else if (tcnt == TO_LAST) begin
                    expire    = 1'b1;
                    state_nxt = S_RESP_STATUS;
                end
            end
            S_RESP_STATUS: if (tx_fire) state_nxt = (status == 8'h00 && !is_wr) ? S_RESP_DATA : S_IDLE;
            S_RESP_DATA:   if (tx_fire && cnt == n_m1) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aud_ck or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge aud_ck or posedge rst) begin
        if (rst) begin
            rx_rdy  <= 1'b0;
            abort_q <= 1'b0;
            is_wr   <= 1'b0;
            size    <= 2'd0;
            cnt     <= 2'd0;
            tcnt    <= '0;
            addr    <= 32'd0;
            wdata   <= 32'd0;
            rbuf    <= 32'd0;
            status  <= 8'h00;
        end else begin
            // Registered from next state so rx_ready is low while in reset.
            rx_rdy  <= (state_nxt == S_IDLE) || (state_nxt == S_ADDR) || (state_nxt == S_WDATA);
            abort_q <= expire;
            case (state)
                S_IDLE: begin
                    if (rx_fire && op_ok) begin
                        is_wr <= bus.rx_data[7];
                        size  <= bus.rx_data[1:0];
                        cnt   <= 2'd0;
                        wdata <= 32'd0;
                    end else if (rx_fire) begin
                        status <= 8'h02;
                    end
                end
                S_ADDR: begin
                    if (rx_fire) begin
                        addr[{cnt, 3'b000} +: 8] <= bus.rx_data;
                        cnt <= cnt + 2'd1;
                    end
                end
                S_WDATA: begin
                    if (rx_fire) begin
                        wdata[{cnt, 3'b000} +: 8] <= bus.rx_data;
                        cnt <= cnt + 2'd1;
                    end
                end
                S_ISSUE: tcnt <= '0;
                S_WAIT: begin
                    if (bus.rmm_done) begin
                        status <= {7'd0, bus.rmm_err};
                        rbuf   <= bus.rmm_rdata;
                    end else if (expire) begin
                        status <= 8'h03;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_RESP_STATUS: if (tx_fire) cnt <= 2'd0;
                S_RESP_DATA:   if (tx_fire) cnt <= cnt + 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            S_RESP_STATUS: tx_byte = status;
            S_RESP_DATA:   tx_byte = rbuf[{cnt, 3'b000} +: 8];
            default:       tx_byte = 8'h00;
        endcase
    end

    assign bus.rx_ready  = rx_rdy;
    assign bus.tx_valid  = tx_vld;
    assign bus.tx_data   = tx_byte;
    assign bus.rmm_addr  = addr;
    assign bus.rmm_wdata = wdata;
    assign bus.rmm_size  = size;
    assign bus.rmm_we    = (state == S_ISSUE) && is_wr;
    assign bus.rmm_re    = (state == S_ISSUE) && !is_wr;
    assign bus.rmm_abort = abort_q;
    assign busy          = (state != S_IDLE);

endmodule
